// File: rtl/fwd_pkg.sv
// Shared codes, forwarding word layout and shadow-slot type for the ID->EX forwarding unit.
// No logic here beyond a pure word-builder helper.
package fwd_pkg;
    localparam int REG_W  = 3;
    localparam int FW_W   = 6;
    localparam int FW_EN  = 3;
    localparam int FW_M2X = 2;

    localparam logic [1:0] WB_ADDPC = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b10;
    localparam logic [1:0] WB_IMM8  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] rd;
        logic [1:0]       wb_sel;
    } slot_t;

    function automatic logic [FW_W-1:0] fw_word(input logic m2x, input logic [1:0] src);
        logic [FW_W-1:0] w;
        w         = '0;
        w[FW_EN]  = 1'b1;
        w[FW_M2X] = m2x;
        w[1:0]    = src;
        return w;
    endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side instruction fields and flush in, stall / forwarding words / event counters out.
// master drives the decode side, slave is the forwarding unit.
interface fwd_hazard_unit_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs_a;
    logic             id_use_a;
    logic [REG_W-1:0] id_rs_b;
    logic             id_use_b;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_reg;
    logic [1:0]       id_wb_sel;
    logic             flush;
    logic             stall;
    logic [5:0]       fwCntrlA;
    logic [5:0]       fwCntrlB;
    logic             ex_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    modport master (
        output id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b,
               id_wr_en, id_wr_reg, id_wb_sel, flush,
        input  stall, fwCntrlA, fwCntrlB, ex_valid, stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b,
               id_wr_en, id_wr_reg, id_wb_sel, flush,
        output stall, fwCntrlA, fwCntrlB, ex_valid, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Per-operand hit detection against the EX and MEM shadow slots; purely combinational.
// The newest producer (EX) wins over MEM.
module fwd_match #(
    parameter int REG_W = 3
) (
    input  logic             use_i,
    input  logic [REG_W-1:0] rs_i,
    input  fwd_pkg::slot_t   ex_i,
    input  fwd_pkg::slot_t   mem_i,
    output logic             hit_e_o,
    output logic [5:0]       word_o
);
    import fwd_pkg::*;

    logic hit_m;

    always_comb begin
        hit_e_o = use_i & ex_i.valid & ex_i.wr_en & (ex_i.rd == rs_i);
        hit_m   = use_i & mem_i.valid & mem_i.wr_en & (mem_i.rd == rs_i);
        word_o  = '0;
        if (hit_e_o) begin
            word_o = fw_word(1'b0, ex_i.wb_sel);
        end else if (hit_m) begin
            word_o = fw_word(1'b1, mem_i.wb_sel);
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadows EX/MEM writers, registers forwarding words for the instruction entering EX (1-cycle latency)
// and stalls IF/ID for one cycle on a load-use hazard, pushing a bubble into EX; flush beats stall.
module fwd_hazard_unit #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus
);
    import fwd_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    slot_t            ex_q, ex_d, mem_q;
    logic [FW_W-1:0]  fw_a_q, fw_a_d, fw_b_q, fw_b_d;
    logic [FW_W-1:0]  word_a, word_b;
    logic             hit_e_a, hit_e_b;
    logic             stall, load;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    fwd_match #(.REG_W(REG_W)) u_match_a (
        .use_i   (bus.id_use_a),
        .rs_i    (bus.id_rs_a),
        .ex_i    (ex_q),
        .mem_i   (mem_q),
        .hit_e_o (hit_e_a),
        .word_o  (word_a)
    );

    fwd_match #(.REG_W(REG_W)) u_match_b (
        .use_i   (bus.id_use_b),
        .rs_i    (bus.id_rs_b),
        .ex_i    (ex_q),
        .mem_i   (mem_q),
        .hit_e_o (hit_e_b),
        .word_o  (word_b)
    );

    always_comb begin
        // A load in EX cannot feed X->X; hold ID one cycle so it forwards M->X instead.
        stall  = bus.id_valid & ~bus.flush & (hit_e_a | hit_e_b) & (ex_q.wb_sel == WB_MEM);
        load   = bus.id_valid & ~stall & ~bus.flush;
        ex_d   = '0;
        fw_a_d = '0;
        fw_b_d = '0;
        if (load) begin
            ex_d.valid  = 1'b1;
            ex_d.wr_en  = bus.id_wr_en;
            ex_d.rd     = bus.id_wr_reg;
            ex_d.wb_sel = bus.id_wb_sel;
            fw_a_d      = word_a;
            fw_b_d      = word_b;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        fwd_cnt_d = fwd_cnt_q;
        if ((fw_a_q[FW_EN] | fw_b_q[FW_EN]) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fw_a_q      <= '0;
            fw_b_q      <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            fw_a_q      <= fw_a_d;
            fw_b_q      <= fw_b_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwCntrlA  = fw_a_q;
    assign bus.fwCntrlB  = fw_b_q;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
endmodule
